blram_dp: RTL and testbench
===========================

BLRAM_DP -- requirements
Module: blram_dp

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- SIZE, 8, address width in bits.
- DEPTH, 2**SIZE, number of words; legal range 2..2**SIZE.
- WIDTH, 16, data width in bits; must be a multiple of 8.
- LAT, 1, read latency in cycles; legal values 1 or 2.
- WMODE, 0, same-port read-during-write behaviour: 0 = read-first (old data), 1 = write-first (new data).
- CLR_EN, 1, 1 = zero-fill the whole array after reset; 0 = skip the fill.

REQ-002 Ports, one per line: name, direction, width, meaning.
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- ready  out  1  high when the array accepts accesses.
- a_en  in  1  port A access enable.
- a_we  in  1  port A write enable; qualified by a_en.
- a_be  in  WIDTH/8  port A byte enables.
- a_addr  in  SIZE  port A address.
- a_din  in  WIDTH  port A write data.
- a_dout  out  WIDTH  port A read data.
- a_rvalid  out  1  port A read-data-valid strobe.
- b_en, b_we, b_be, b_addr, b_din, b_dout, b_rvalid: same as port A, for port B.
- collide  out  1  single-cycle pulse on a write/write address collision.

Function
REQ-003 The FSM SHALL have exactly two states: CLEAR and RUN.
REQ-004 CLEAR SHALL write zero to one address per cycle using an internal counter clr_addr, counting 0..DEPTH-1, then enter RUN.
REQ-005 With CLR_EN=1, ready SHALL rise exactly DEPTH cycles after the first rising clk edge following rst release.
REQ-006 With CLR_EN=0, the block SHALL enter RUN on the first rising edge after rst release, with array contents undefined.
REQ-007 In CLEAR, all port accesses SHALL be ignored, and a_rvalid, b_rvalid and collide SHALL stay 0.
REQ-008 In RUN, a write SHALL update only the bytes whose be bit is 1; other bytes keep their old value.
REQ-009 A read occurs whenever en=1; a write cycle with en=1 is also a read.
REQ-010 Read data SHALL appear on dout, with rvalid=1, exactly LAT cycles after the cycle in which en was sampled.
REQ-011 rvalid SHALL be a single-cycle pulse per access.
REQ-012 When rvalid=0, dout SHALL hold its last value.
REQ-013 With LAT=2, accesses SHALL be fully pipelined: back-to-back reads yield back-to-back rvalid pulses.
REQ-014 For a same-port read and write at the same address, dout SHALL return the old word when WMODE=0, or the merged new word when WMODE=1.
REQ-015 For a cross-port read of an address being written in the same cycle, the read SHALL return the old word, independent of WMODE.
REQ-016 If both ports write the same address in the same cycle, port A's enabled bytes SHALL win and collide SHALL pulse high for one cycle.
- Any bytes enabled only by port B SHALL still be written.
REQ-017 Addresses at or above DEPTH SHALL be ignored on write, and SHALL read as zero with a normal rvalid pulse.
REQ-018 clr_addr SHALL NOT wrap; the transition to RUN occurs at DEPTH-1.

Reset
REQ-019 While rst=0, the following SHALL be held: state=CLEAR (or RUN when CLR_EN=0), clr_addr=0, ready=0, a_dout=b_dout=0, a_rvalid=b_rvalid=0, collide=0, and all pipeline stages cleared.
REQ-020 rst asserted mid-operation, whether during CLEAR or during a pipelined read, SHALL cancel all in-flight reads with no rvalid pulse.
- When CLR_EN=1, the zero-fill SHALL restart from address 0.
REQ-021 Array contents SHALL NOT be reset asynchronously; only the CLEAR sequence zeroes them.

Structure
REQ-022 The shared package tinymips_pkg SHALL hold the state encoding constants (ST_CLEAR, ST_RUN) and the default WIDTH and SIZE values shared with TinyMIPS.
REQ-023 One sub-module, blram_rdpipe, SHALL implement the per-port LAT-stage dout/rvalid pipeline; it is instantiated once per port.
REQ-024 blram_dp SHALL be a drop-in replacement for blram when port B is tied off (b_en=0).
- Port A then maps we/addr/din/dout, with a_be all ones and a_en=1.

Verification
REQ-025 CLR_EN=1, DEPTH=256, preload mem with nonzero junk, release rst -> ready rises at cycle 256; a subsequent read of address 0x7F returns 0x0000.
REQ-026 LAT=2, write 0x1234 to 0x0A, then read 0x0A on A while reading 0x0B on B -> a_dout=0x1234 with a_rvalid exactly 2 cycles after the read request; b_rvalid pulses in the same cycle.
REQ-027 WMODE=0 vs WMODE=1 -> A writes 0xBEEF over 0x1111 at 0x05 with a read in the same cycle -> a_dout=0x1111 (WMODE=0) or 0xBEEF (WMODE=1).
REQ-028 A writes 0xAAAA with be=2'b11 and B writes 0x5555 with be=2'b11 to 0x20 in the same cycle -> collide pulses once; a later read returns 0xAAAA.
- Variant: A with be=2'b01 and B with be=2'b10 -> read returns 0x55AA.
REQ-029 Assert rst at cycle 100 of CLEAR, then release -> ready stays 0 until 256 cycles after the release.
- During a LAT=2 read, a reset produces no rvalid pulse.
REQ-030 Run the TinyMIPS summation program (sum of 5, 8, 15, 17 and 22) with blram_dp in place of blram, CLR_EN=0, LAT=1 -> RF[2]=67.

Source files
------------

// File: rtl/tinymips_pkg.sv
// rtl/tinymips_pkg.sv - Shared TinyMIPS constants and the block-RAM controller state encoding.
package tinymips_pkg;

  localparam int TM_WIDTH = 16;
  localparam int TM_SIZE  = 8;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } blram_state_t;

endpackage

// File: rtl/blram_rdpipe.sv
// rtl/blram_rdpipe.sv - LAT-stage read-data/valid pipeline for one RAM port.
module blram_rdpipe #(
  parameter int WIDTH = 16,
  parameter int LAT   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] dout,
  output logic             rvalid
);

  logic [LAT-1:0]   v;
  logic [WIDTH-1:0] d [LAT];

  // Data stages only load on a valid beat, so the last stage holds between pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v <= '0;
      for (int i = 0; i < LAT; i++) begin
        d[i] <= '0;
      end
    end else begin
      v[0] <= req;
      if (req) begin
        d[0] <= data;
      end
      for (int i = 1; i < LAT; i++) begin
        v[i] <= v[i-1];
        if (v[i-1]) begin
          d[i] <= d[i-1];
        end
      end
    end
  end

  assign dout   = d[LAT-1];
  assign rvalid = v[LAT-1];

endmodule

// File: rtl/blram_dp.sv
// rtl/blram_dp.sv - True dual-port byte-writable RAM with post-reset zero fill.
module blram_dp
  import tinymips_pkg::*;
#(
  parameter int SIZE   = TM_SIZE,
  parameter int DEPTH  = 2**SIZE,
  parameter int WIDTH  = TM_WIDTH,
  parameter int LAT    = 1,
  parameter int WMODE  = 0,
  parameter int CLR_EN = 1
) (
  input  logic               clk,
  input  logic               rst,
  output logic               ready,
  input  logic               a_en,
  input  logic               a_we,
  input  logic [WIDTH/8-1:0] a_be,
  input  logic [SIZE-1:0]    a_addr,
  input  logic [WIDTH-1:0]   a_din,
  output logic [WIDTH-1:0]   a_dout,
  output logic               a_rvalid,
  input  logic               b_en,
  input  logic               b_we,
  input  logic [WIDTH/8-1:0] b_be,
  input  logic [SIZE-1:0]    b_addr,
  input  logic [WIDTH-1:0]   b_din,
  output logic [WIDTH-1:0]   b_dout,
  output logic               b_rvalid,
  output logic               collide
);

  localparam int NB = WIDTH / 8;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam blram_state_t ST_INIT = (CLR_EN != 0) ? ST_CLEAR : ST_RUN;

  blram_state_t    state, state_nxt;
  logic [SIZE-1:0] clr_addr, clr_addr_nxt;

  logic [WIDTH-1:0] mem [DEPTH];

  logic             a_acc, b_acc;
  logic             a_wr, b_wr;
  logic [AW-1:0]    a_idx, b_idx, clr_idx;
  logic [WIDTH-1:0] a_rword, b_rword;

  function automatic logic in_range(input logic [SIZE-1:0] ad);
    return 32'(ad) < 32'(DEPTH);
  endfunction

  function automatic logic [WIDTH-1:0] merge_be(input logic [WIDTH-1:0] old,
                                                input logic [WIDTH-1:0] din,
                                                input logic [NB-1:0]    be);
    logic [WIDTH-1:0] r;
    r = old;
    for (int i = 0; i < NB; i++) begin
      if (be[i]) begin
        r[i*8 +: 8] = din[i*8 +: 8];
      end
    end
    return r;
  endfunction

  always_comb begin
    state_nxt    = state;
    clr_addr_nxt = clr_addr;
    if (state == ST_CLEAR) begin
      // Leave CLEAR on the last address instead of wrapping the counter.
      if (32'(clr_addr) == 32'(DEPTH - 1)) begin
        state_nxt = ST_RUN;
      end else begin
        clr_addr_nxt = clr_addr + SIZE'(1);
      end
    end
  end

  // ready doubles as the access gate so CLR_EN=0 accepts nothing while rst is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_INIT;
      clr_addr <= '0;
      ready    <= 1'b0;
      collide  <= 1'b0;
    end else begin
      state    <= state_nxt;
      clr_addr <= clr_addr_nxt;
      ready    <= (state_nxt == ST_RUN);
      collide  <= a_wr && b_wr && (a_addr == b_addr);
    end
  end

  assign a_acc   = ready && a_en;
  assign b_acc   = ready && b_en;
  assign a_wr    = a_acc && a_we && in_range(a_addr);
  assign b_wr    = b_acc && b_we && in_range(b_addr);
  assign a_idx   = a_addr[AW-1:0];
  assign b_idx   = b_addr[AW-1:0];
  assign clr_idx = clr_addr[AW-1:0];

  // Port A's byte writes come last so they override port B on a collision.
  always_ff @(posedge clk) begin
    if (state == ST_CLEAR) begin
      mem[clr_idx] <= '0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (b_wr && b_be[i]) begin
          mem[b_idx][i*8 +: 8] <= b_din[i*8 +: 8];
        end
        if (a_wr && a_be[i]) begin
          mem[a_idx][i*8 +: 8] <= a_din[i*8 +: 8];
        end
      end
    end
  end

  // Array is sampled before the edge: cross-port reads always see the old word.
  always_comb begin
    a_rword = '0;
    if (in_range(a_addr)) begin
      a_rword = (WMODE != 0 && a_wr) ? merge_be(mem[a_idx], a_din, a_be) : mem[a_idx];
    end
  end

  always_comb begin
    b_rword = '0;
    if (in_range(b_addr)) begin
      b_rword = (WMODE != 0 && b_wr) ? merge_be(mem[b_idx], b_din, b_be) : mem[b_idx];
    end
  end

  blram_rdpipe #(
    .WIDTH (WIDTH),
    .LAT   (LAT)
  ) u_a_pipe (
    .clk    (clk),
    .rst    (rst),
    .req    (a_acc),
    .data   (a_rword),
    .dout   (a_dout),
    .rvalid (a_rvalid)
  );

  blram_rdpipe #(
    .WIDTH (WIDTH),
    .LAT   (LAT)
  ) u_b_pipe (
    .clk    (clk),
    .rst    (rst),
    .req    (b_acc),
    .data   (b_rword),
    .dout   (b_dout),
    .rvalid (b_rvalid)
  );

endmodule

// File: tb/tb_blram_dp.sv
// tb/tb_blram_dp.sv - Directed bench: u0 is LAT=2/read-first/full depth, u1 is LAT=1/write-first/DEPTH=200.
module tb_blram_dp;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_en, a_we, b_en, b_we;
  logic [1:0]  a_be, b_be;
  logic [7:0]  a_addr, b_addr;
  logic [15:0] a_din, b_din;

  logic        r0, av0, bv0, c0;
  logic [15:0] ad0, bd0;
  logic        r1, av1, bv1, c1;
  logic [15:0] ad1, bd1;

  int   checks   = 0;
  int   failures = 0;
  int   n0, n1;
  logic seen;

  always #5 clk = ~clk;

  blram_dp #(.SIZE(8), .DEPTH(256), .WIDTH(16), .LAT(2), .WMODE(0), .CLR_EN(1)) u0 (
    .clk(clk), .rst(rst), .ready(r0),
    .a_en(a_en), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_din(a_din),
    .a_dout(ad0), .a_rvalid(av0),
    .b_en(b_en), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_din(b_din),
    .b_dout(bd0), .b_rvalid(bv0),
    .collide(c0)
  );

  blram_dp #(.SIZE(8), .DEPTH(200), .WIDTH(16), .LAT(1), .WMODE(1), .CLR_EN(1)) u1 (
    .clk(clk), .rst(rst), .ready(r1),
    .a_en(a_en), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_din(a_din),
    .a_dout(ad1), .a_rvalid(av1),
    .b_en(b_en), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_din(b_din),
    .b_dout(bd1), .b_rvalid(bv1),
    .collide(c1)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_en = 1'b0; a_we = 1'b0;
    b_en = 1'b0; b_we = 1'b0;
  endtask

  task automatic set_a(input logic we, input logic [7:0] ad, input logic [15:0] d, input logic [1:0] be);
    a_en = 1'b1; a_we = we; a_addr = ad; a_din = d; a_be = be;
  endtask

  task automatic set_b(input logic we, input logic [7:0] ad, input logic [15:0] d, input logic [1:0] be);
    b_en = 1'b1; b_we = we; b_addr = ad; b_din = d; b_be = be;
  endtask

  task automatic wr_a(input logic [7:0] ad, input logic [15:0] d);
    set_a(1'b1, ad, d, 2'b11);
    step();
    idle();
    step();
    step();
  endtask

  // Counts edges after rst release until u0 is ready; optional access noise for the first 150 edges.
  task automatic count_ready(input logic noise);
    n0 = 0; n1 = 0; seen = 1'b0;
    for (int n = 1; n <= 400 && n0 == 0; n++) begin
      if (n == 151) idle();
      step();
      if (noise && n <= 150) seen = seen | av0 | bv0 | c0 | av1 | bv1 | c1 | r0 | r1;
      if (r1 && n1 == 0) n1 = n;
      if (r0 && n0 == 0) n0 = n;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    idle();
    a_be = 2'b00; b_be = 2'b00; a_addr = '0; b_addr = '0; a_din = '0; b_din = '0;
    step();
    set_a(1'b0, 8'h01, 16'h0, 2'b11);
    step();
    chk1("rst_ready_u0", r0, 1'b0);
    chk1("rst_ready_u1", r1, 1'b0);
    chk1("rst_arvalid_u0", av0, 1'b0);
    chk1("rst_brvalid_u1", bv1, 1'b0);
    chk16("rst_adout_u0", ad0, 16'h0000);
    chk1("rst_collide_u0", c0, 1'b0);

    // First fill with write/collision traffic that must be ignored.
    rst = 1'b1;
    set_a(1'b1, 8'h03, 16'hFFFF, 2'b11);
    set_b(1'b1, 8'h03, 16'h0F0F, 2'b11);
    count_ready(1'b1);
    chk1("clear_quiet", seen, 1'b0);
    chk16("ready_edge_u0", 16'(n0), 16'd256);
    chk16("ready_edge_u1", 16'(n1), 16'd200);

    set_a(1'b0, 8'h03, 16'h0, 2'b00);
    step();
    chk1("rd3_valid_u1", av1, 1'b1);
    chk16("rd3_data_u1", ad1, 16'h0000);
    chk1("rd3_lat_u0", av0, 1'b0);
    idle();
    step();
    chk1("rd3_valid_u0", av0, 1'b1);
    chk16("rd3_data_u0", ad0, 16'h0000);
    step();

    // Write then dual-port read, back-to-back on A.
    wr_a(8'h0A, 16'h1234);
    set_a(1'b0, 8'h0A, 16'h0, 2'b00);
    set_b(1'b0, 8'h0B, 16'h0, 2'b00);
    step();
    chk16("rdA_u1", ad1, 16'h1234);
    chk1("rdB_valid_u1", bv1, 1'b1);
    chk1("rdA_early_u0", av0, 1'b0);
    chk1("rdB_early_u0", bv0, 1'b0);
    idle();
    set_a(1'b0, 8'h0B, 16'h0, 2'b00);
    step();
    chk1("rdA_valid_u0", av0, 1'b1);
    chk16("rdA_data_u0", ad0, 16'h1234);
    chk1("rdB_valid_u0", bv0, 1'b1);
    chk16("rdB_data_u0", bd0, 16'h0000);
    chk1("rdB_pulse_u1", bv1, 1'b0);
    idle();
    step();
    chk1("b2b_valid_u0", av0, 1'b1);
    chk16("b2b_data_u0", ad0, 16'h0000);
    step();
    chk1("b2b_end_u0", av0, 1'b0);

    // Same-port read-during-write and cross-port read.
    wr_a(8'h05, 16'h1111);
    set_a(1'b1, 8'h05, 16'hBEEF, 2'b11);
    set_b(1'b0, 8'h05, 16'h0, 2'b00);
    step();
    chk16("rdw_wfirst_u1", ad1, 16'hBEEF);
    chk16("xport_old_u1", bd1, 16'h1111);
    idle();
    step();
    chk16("rdw_rfirst_u0", ad0, 16'h1111);
    chk16("xport_old_u0", bd0, 16'h1111);
    chk1("hold_valid_u1", av1, 1'b0);
    chk16("hold_data_u1", ad1, 16'hBEEF);
    step();
    chk16("hold_data_u0", ad0, 16'h1111);
    set_b(1'b0, 8'h05, 16'h0, 2'b00);
    step();
    chk16("rd5_u1", bd1, 16'hBEEF);
    idle();
    step();
    chk16("rd5_u0", bd0, 16'hBEEF);
    step();

    // Write/write collision, full then split byte enables.
    set_a(1'b1, 8'h20, 16'hAAAA, 2'b11);
    set_b(1'b1, 8'h20, 16'h5555, 2'b11);
    step();
    chk1("collide_u0", c0, 1'b1);
    chk1("collide_u1", c1, 1'b1);
    idle();
    step();
    chk1("collide_pulse_u0", c0, 1'b0);
    step();
    set_a(1'b0, 8'h20, 16'h0, 2'b00);
    step();
    chk16("coll_full_u1", ad1, 16'hAAAA);
    idle();
    step();
    chk16("coll_full_u0", ad0, 16'hAAAA);
    step();
    set_a(1'b1, 8'h20, 16'hAAAA, 2'b01);
    set_b(1'b1, 8'h20, 16'h5555, 2'b10);
    step();
    chk1("collide_be_u1", c1, 1'b1);
    idle();
    step();
    step();
    set_a(1'b0, 8'h20, 16'h0, 2'b00);
    step();
    chk16("coll_be_u1", ad1, 16'h55AA);
    idle();
    step();
    chk16("coll_be_u0", ad0, 16'h55AA);
    step();

    // Address 0xC8 is beyond u1's depth but inside u0's.
    wr_a(8'hC8, 16'h7777);
    set_a(1'b0, 8'hC8, 16'h0, 2'b00);
    step();
    chk1("oor_valid_u1", av1, 1'b1);
    chk16("oor_data_u1", ad1, 16'h0000);
    idle();
    step();
    chk16("inr_data_u0", ad0, 16'h7777);
    step();

    // Reset with a LAT=2 read in flight, then reset again mid-fill.
    wr_a(8'h7F, 16'hDEAD);
    set_a(1'b0, 8'h7F, 16'h0, 2'b00);
    step();
    chk16("junk_u1", ad1, 16'hDEAD);
    idle();
    rst = 1'b0;
    #1;
    chk1("cancel_valid_u0", av0, 1'b0);
    chk16("cancel_dout_u0", ad0, 16'h0000);
    step();
    chk1("cancel_late_u0", av0, 1'b0);
    step();
    rst = 1'b1;
    for (int n = 0; n < 100; n++) step();
    chk1("mid_clear_ready_u0", r0, 1'b0);
    rst = 1'b0;
    step();
    rst = 1'b1;
    count_ready(1'b0);
    chk16("refill_edge_u0", 16'(n0), 16'd256);
    chk16("refill_edge_u1", 16'(n1), 16'd200);

    step();
    wr_a(8'h0A, 16'h4321);
    set_a(1'b0, 8'h0A, 16'h0, 2'b00);
    step();
    chk16("post_rd0A_u1", ad1, 16'h4321);
    set_a(1'b0, 8'h7F, 16'h0, 2'b00);
    step();
    chk1("post_rd7F_valid_u1", av1, 1'b1);
    chk16("post_rd7F_u1", ad1, 16'h0000);
    chk16("post_rd0A_u0", ad0, 16'h4321);
    idle();
    step();
    chk1("post_rd7F_valid_u0", av0, 1'b1);
    chk16("post_rd7F_u0", ad0, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
